// File: rtl/comparator_arbiter_2ch.sv
// Two requesters share one combinational 4-bit comparator through a
// round-robin IDLE -> CMP -> DONE sequencer with registered results.
`timescale 1ns/1ps

module comparator_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic       o_eq,
    output logic       o_gt,
    output logic       o_lt
);
    assign o_eq = (i_a == i_b);
    assign o_gt = (i_a >  i_b);
    assign o_lt = (i_a <  i_b);
endmodule

module comparator_arbiter_2ch (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req0,
    input  logic [3:0] i_a0,
    input  logic [3:0] i_b0,
    input  logic       i_req1,
    input  logic [3:0] i_a1,
    input  logic [3:0] i_b1,
    output logic       o_gnt0,
    output logic       o_gnt1,
    output logic       o_eq,
    output logic       o_gt,
    output logic       o_lt,
    output logic       o_busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_owner;
    logic       r_last;
    logic       r_eq;
    logic       r_gt;
    logic       r_lt;

    logic       w_any_req;
    logic       w_pick;
    logic       w_cmp_eq;
    logic       w_cmp_gt;
    logic       w_cmp_lt;

    comparator_4bit u_cmp (
        .i_a  (r_a),
        .i_b  (r_b),
        .o_eq (w_cmp_eq),
        .o_gt (w_cmp_gt),
        .o_lt (w_cmp_lt)
    );

    // Under contention the requester not granted last time wins.
    assign w_any_req = i_req0 | i_req1;
    assign w_pick    = (i_req0 & i_req1) ? ~r_last : i_req1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_nxt = w_any_req ? S_CMP : S_IDLE;
            S_CMP:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_a     <= 4'd0;
            r_b     <= 4'd0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_any_req) begin
                r_owner <= w_pick;
                r_last  <= w_pick;
                r_a     <= w_pick ? i_a1 : i_a0;
                r_b     <= w_pick ? i_b1 : i_b0;
            end
            if (r_state == S_CMP) begin
                r_eq <= w_cmp_eq;
                r_gt <= w_cmp_gt;
                r_lt <= w_cmp_lt;
            end
        end
    end

    assign o_gnt0 = (r_state == S_DONE) && (r_owner == 1'b0);
    assign o_gnt1 = (r_state == S_DONE) && (r_owner == 1'b1);
    assign o_eq   = r_eq;
    assign o_gt   = r_gt;
    assign o_lt   = r_lt;
    assign o_busy = (r_state != S_IDLE);
endmodule

// File: tb/tb_comparator_arbiter_2ch.sv
// Directed bench for comparator_arbiter_2ch: latency, round-robin order,
// operand capture, reset abort and a full sweep of operand pairs.
`timescale 1ns/1ps

module tb_comparator_arbiter_2ch;
    logic       clk;
    logic       rst;
    logic       req0;
    logic [3:0] a0;
    logic [3:0] b0;
    logic       req1;
    logic [3:0] a1;
    logic [3:0] b1;
    logic       gnt0;
    logic       gnt1;
    logic       eq;
    logic       gt;
    logic       lt;
    logic       busy;

    int n_tests;
    int n_fail;

    comparator_arbiter_2ch dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_req0 (req0),
        .i_a0   (a0),
        .i_b0   (b0),
        .i_req1 (req1),
        .i_a1   (a1),
        .i_b1   (b1),
        .o_gnt0 (gnt0),
        .o_gnt1 (gnt1),
        .o_eq   (eq),
        .o_gt   (gt),
        .o_lt   (lt),
        .o_busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs outputs as {gnt0,gnt1,busy,eq,gt,lt}
    function automatic logic [7:0] outs();
        return {2'b00, gnt0, gnt1, busy, eq, gt, lt};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;

        do_reset();
        chk("reset_outputs", outs(), 8'b000000);

        // Single request from requester 0: 9 vs 7
        req0 = 1'b1; a0 = 4'b1001; b0 = 4'b0111;
        chk("t1_k_idle", outs(), 8'b000000);
        step();
        chk("t1_k1_busy", outs(), 8'b001000);
        step();
        chk("t1_k2_gnt0_gt", outs(), 8'b101010);
        req0 = 1'b0;
        step();
        chk("t1_k3_idle", outs(), 8'b000010);
        step();
        chk("t1_k4_idle", outs(), 8'b000010);

        // Contention: requester 0 wins first after reset, then requester 1
        do_reset();
        req0 = 1'b1; a0 = 4'b1010; b0 = 4'b1010;
        req1 = 1'b1; a1 = 4'b0000; b1 = 4'b1111;
        step();
        chk("t2_k1_busy", outs(), 8'b001000);
        step();
        chk("t2_k2_gnt0_eq", outs(), 8'b101100);
        req0 = 1'b0;
        step();
        chk("t2_k3_idle", outs(), 8'b000100);
        step();
        chk("t2_k4_busy", outs(), 8'b001100);
        step();
        chk("t2_k5_gnt1_lt", outs(), 8'b011001);
        req1 = 1'b0;
        step();
        chk("t2_k6_idle", outs(), 8'b000001);

        // Both held continuously: grants alternate 0,1,0,1 every 3 cycles
        do_reset();
        req0 = 1'b1; a0 = 4'd5; b0 = 4'd2;
        req1 = 1'b1; a1 = 4'd2; b1 = 4'd5;
        for (int g = 0; g < 4; g++) begin
            step();
            chk("t3_cmp_nogrant", {6'd0, gnt0, gnt1}, 8'b00);
            step();
            if (g % 2 == 0)
                chk("t3_gnt0_gt", outs(), 8'b101010);
            else
                chk("t3_gnt1_lt", outs(), 8'b011001);
            step();
            chk("t3_idle", {5'd0, gnt0, gnt1, busy}, 8'b000);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
        step();

        // Operand change after capture does not affect the result
        do_reset();
        req0 = 1'b1; a0 = 4'b1111; b0 = 4'b0000;
        step();
        a0 = 4'b0000;
        step();
        chk("t4_captured_gt", outs(), 8'b101010);
        req0 = 1'b0;
        step();

        // Reset during CMP aborts; held req1 is served after release
        do_reset();
        req1 = 1'b1; a1 = 4'd3; b1 = 4'd3;
        step();
        chk("t5_in_cmp", outs(), 8'b001000);
        rst = 1'b1;
        step();
        chk("t5_after_rst", outs(), 8'b000000);
        rst = 1'b0;
        step();
        chk("t5_rel_k1_busy", outs(), 8'b001000);
        step();
        chk("t5_rel_k2_gnt1_eq", outs(), 8'b011100);
        req1 = 1'b0;
        step();
        chk("t5_rel_k3_idle", outs(), 8'b000100);

        // Exhaustive sweep through requester 1
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [7:0] exp_v;
                req1 = 1'b1;
                a1 = 4'(a);
                b1 = 4'(b);
                step();
                step();
                exp_v = {2'b00, 1'b0, 1'b1, 1'b1, (a == b), (a > b), (a < b)};
                chk("sweep", outs(), exp_v);
                req1 = 1'b0;
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
